// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier with start-edge detect and operand capture.
// Two multiplier bits are retired per clock; signed or unsigned operation is chosen per transaction.
//
// state | meaning
// IDLE  | waiting for a start edge; operands captured on the edge
// RUN   | one Booth iteration per cycle, DW/2+1 iterations
// DONE  | one-cycle ready pulse, then back to IDLE
module booth_r4_multiplier #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic            busy,
  output logic            ready,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW/2+2);
  localparam int XW = DW + 2;
  localparam int AW = 2*XW + 1;
  localparam int N  = DW/2 + 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            start_q;
  logic            start_edge;
  logic [XW-1:0]   m_ext;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_next;
  logic [CW-1:0]   cnt;
  logic [XW+1:0]   m_wide;
  logic [XW+1:0]   addend;
  logic [XW+1:0]   sum;
  logic [XW-1:0]   a_ext;
  logic [XW-1:0]   b_ext;

  assign start_edge = start & ~start_q;
  assign a_ext = {{2{signed_mode & multiplicand[DW-1]}}, multiplicand};
  assign b_ext = {{2{signed_mode & multiplier[DW-1]}}, multiplier};

  // Two guard bits keep +/-2M and the running sum from wrapping before the shift.
  assign m_wide = {{2{m_ext[XW-1]}}, m_ext};

  always_comb begin
    addend = '0;
    case (acc[2:0])
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = -(m_wide << 1);
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;
    endcase
  end

  assign sum      = {{2{acc[AW-1]}}, acc[AW-1 -: XW]} + addend;
  assign acc_next = {sum, acc[XW:2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      product <= '0;
      m_ext   <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      start_q <= start;
      busy    <= (state_next != IDLE);
      ready   <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start_edge) begin
            m_ext <= a_ext;
            acc   <= {{XW{1'b0}}, b_ext, 1'b0};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) product <= acc_next[2*DW:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed bench for booth_r4_multiplier at DW=8 (N=5): products, latency, handshake and reset.
module tb_booth_r4_multiplier;

  localparam int DW = 8;
  localparam int N  = DW/2 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            signed_mode;
  logic [DW-1:0]   multiplicand;
  logic [DW-1:0]   multiplier;
  logic            busy;
  logic            ready;
  logic [2*DW-1:0] product;

  int total = 0;
  int bad   = 0;
  int cyc;
  int bcnt;
  int rcnt;

  booth_r4_multiplier #(.DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .ready        (ready),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; leaves the bench in the first IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    chk({tag, "_accept"}, busy, 1'b1);
    start = 1'b0;
    cyc   = 0;
    bcnt  = 1;
    while (!ready && cyc < 20) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
    chk({tag, "_latency"}, cyc, N);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_cycles"}, bcnt, N + 1);
    tick();
    chk({tag, "_ready_pulse"}, ready, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_product", product, 16'h0000);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back calls also exercise a start edge in the first IDLE cycle after DONE.
    do_op("u_7x6",   1'b0, 8'h07, 8'h06, 16'h002A);
    do_op("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    do_op("s_80x7f", 1'b1, 8'h80, 8'h7F, 16'hC080);
    do_op("s_fdx05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    do_op("u_fdx05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
    do_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    do_op("s_ffxff", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    do_op("u_0x5a",  1'b0, 8'h00, 8'h5A, 16'h0000);

    // Start held high for 20 cycles: exactly one transaction.
    signed_mode  = 1'b0;
    multiplicand = 8'h02;
    multiplier   = 8'h03;
    start        = 1'b1;
    rcnt         = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready) rcnt++;
    end
    start = 1'b0;
    chk("hold_ready_count", rcnt, 1);
    chk("hold_product", product, 16'h0006);
    tick();

    // Second start edge at T0+2 is ignored and not queued.
    multiplicand = 8'h03;
    multiplier   = 8'h04;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = 8'h09;
    multiplier   = 8'h09;
    tick();
    start = 1'b1;
    tick();
    chk("inject_busy", busy, 1'b1);
    start = 1'b0;
    cyc   = 2;
    while (!ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("inject_latency", cyc, N);
    chk("inject_product", product, 16'h000C);
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) rcnt++;
    end
    chk("inject_no_requeue", rcnt, 0);

    // Operand changes after acceptance do not affect the transaction.
    signed_mode  = 1'b0;
    multiplicand = 8'h07;
    multiplier   = 8'h06;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    signed_mode  = 1'b1;
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    cyc          = 0;
    while (!ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("stable_product", product, 16'h002A);
    for (int i = 0; i < 3; i++) tick();
    chk("stable_hold_idle", product, 16'h002A);
    signed_mode  = 1'b0;
    multiplicand = 8'h03;
    multiplier   = 8'h05;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stable_hold_run", product, 16'h002A);
    cyc = 2;
    while (!ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("next_product", product, 16'h000F);
    tick();

    // Asynchronous reset in the middle of a run.
    multiplicand = 8'h05;
    multiplier   = 8'h05;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_product", product, 16'h0000);
    #3;
    rst  = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) rcnt++;
    end
    chk("postrst_no_ready", rcnt, 0);
    chk("postrst_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
